dmem_responder: RTL and testbench

// - Responder end of the pipelined core's data bus (daddr/ddata_w/ddata_r/d_rw).
// - Serves the core's MEM-stage accesses: word RAM in the low half of the map, MMIO registers in the high half.
// - MMIO registers are a free-running cycle counter, a compare timer with sticky IRQ flag, and GPIO out/in.
// - Sits beside the core in the top level; the core latches ddata_r into MEM/WB, so reads must resolve in the same cycle.

---
 rtl/dmem_responder_if.sv | 11 +
 rtl/dmem_responder.sv | 114 +++++++++++
 tb/tb_dmem_responder.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/dmem_responder_if.sv
// Core-side data bus bundle: byte address, write data/strobe and same-cycle read data.
// Read data is combinational and there is no backpressure; every access completes in its own cycle.
interface dmem_responder_if;
  logic [9:0]  daddr;
  logic [31:0] ddata_w;
  logic        d_rw;
  logic [31:0] ddata_r;

  modport master (output daddr, ddata_w, d_rw, input ddata_r);
  modport slave  (input daddr, ddata_w, d_rw, output ddata_r);
endinterface

// File: rtl/dmem_responder.sv
// Data-bus responder: word RAM (low half) and MMIO cycle counter/timer/GPIO (high half).
// Reads are zero-latency combinational; writes land on the rising edge; never stalls the core.
module dmem_responder #(
  parameter int RAM_WORDS = 128,
  parameter int GPIO_W    = 8
) (
  input  logic              CLK,
  input  logic              RESET,
  dmem_responder_if.slave   bus,
  output logic [GPIO_W-1:0] gpio_out,
  input  logic [GPIO_W-1:0] gpio_in,
  output logic              timer_irq
);

  localparam int IDX_W = $clog2(RAM_WORDS);

  localparam logic [2:0] OFF_CYCLE = 3'd0;
  localparam logic [2:0] OFF_TCMP  = 3'd1;
  localparam logic [2:0] OFF_TCTRL = 3'd2;
  localparam logic [2:0] OFF_TSTAT = 3'd3;
  localparam logic [2:0] OFF_GOUT  = 3'd4;
  localparam logic [2:0] OFF_GIN   = 3'd5;

  logic [31:0]       mem_q [RAM_WORDS];
  logic [31:0]       cycle_q, cycle_d;
  logic [31:0]       tcmp_q, tcmp_d;
  logic              ten_q, ten_d;
  logic              flag_q, flag_d;
  logic [GPIO_W-1:0] gout_q, gout_d;
  logic [GPIO_W-1:0] gsync1_q, gsync2_q;

  logic              is_mmio;
  logic [2:0]        mmio_off;
  logic [IDX_W-1:0]  ram_idx;
  logic              mmio_we;
  logic              ram_we;
  logic              match;
  logic [31:0]       rdata;
  logic              unused_addr;

  assign is_mmio     = bus.daddr[9];
  assign mmio_off    = bus.daddr[4:2];
  // Index truncation gives modulo-depth wrap, so a short RAM never reads X from outside its range.
  assign ram_idx     = bus.daddr[2 +: IDX_W];
  assign mmio_we     = bus.d_rw & is_mmio;
  assign ram_we      = bus.d_rw & ~is_mmio & ~RESET;
  assign match       = ten_q & (cycle_q == tcmp_q);
  assign unused_addr = ^{bus.daddr[1:0], bus.daddr[8:5]};

  always_comb begin
    rdata = '0;
    if (!is_mmio) begin
      rdata = mem_q[ram_idx];
    end else begin
      case (mmio_off)
        OFF_CYCLE: rdata = cycle_q;
        OFF_TCMP:  rdata = tcmp_q;
        OFF_TCTRL: rdata[0] = ten_q;
        OFF_TSTAT: rdata[0] = flag_q;
        OFF_GOUT:  rdata[GPIO_W-1:0] = gout_q;
        OFF_GIN:   rdata[GPIO_W-1:0] = gsync2_q;
        default:   rdata = '0;
      endcase
    end
  end

  always_comb begin
    cycle_d = cycle_q + 32'd1;
    tcmp_d  = tcmp_q;
    ten_d   = ten_q;
    gout_d  = gout_q;
    flag_d  = flag_q;
    if (mmio_we) begin
      case (mmio_off)
        OFF_TCMP:  tcmp_d = bus.ddata_w;
        OFF_TCTRL: ten_d  = bus.ddata_w[0];
        OFF_TSTAT: if (bus.ddata_w[0]) flag_d = 1'b0;
        OFF_GOUT:  gout_d = bus.ddata_w[GPIO_W-1:0];
        default:   ;
      endcase
    end
    // A match on the same edge as a W1C clear must leave the flag set.
    if (match) flag_d = 1'b1;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      cycle_q  <= '0;
      tcmp_q   <= '0;
      ten_q    <= 1'b0;
      flag_q   <= 1'b0;
      gout_q   <= '0;
      gsync1_q <= '0;
      gsync2_q <= '0;
    end else begin
      cycle_q  <= cycle_d;
      tcmp_q   <= tcmp_d;
      ten_q    <= ten_d;
      flag_q   <= flag_d;
      gout_q   <= gout_d;
      gsync1_q <= gpio_in;
      gsync2_q <= gsync1_q;
    end
  end

  always_ff @(posedge CLK) begin
    if (ram_we) mem_q[ram_idx] <= bus.ddata_w;
  end

  assign bus.ddata_r = rdata;
  assign gpio_out    = gout_q;
  assign timer_irq   = flag_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: reads are scoreboarded through a queue of expected values.
module tb_dmem_responder;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [7:0] gpio_out;
  logic [7:0] gpio_in;
  logic       timer_irq;

  dmem_responder_if bus();

  dmem_responder #(.RAM_WORDS(128), .GPIO_W(8)) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .bus       (bus),
    .gpio_out  (gpio_out),
    .gpio_in   (gpio_in),
    .timer_irq (timer_irq)
  );

  always #50 CLK = ~CLK;

  int          n_asserts = 0;
  int          n_fails   = 0;
  logic [31:0] exp_q[$];
  string       tag_q[$];
  logic [31:0] cyc;
  logic [31:0] t;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [9:0] a, input logic [31:0] e, input string tag);
    logic [31:0] x;
    string       tg;
    bus.daddr = a;
    bus.d_rw  = 1'b0;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    #1;
    x  = exp_q.pop_front();
    tg = tag_q.pop_front();
    chk(tg, bus.ddata_r, x);
  endtask

  task automatic tick();
    @(negedge CLK);
    cyc = cyc + 32'd1;
  endtask

  task automatic wr(input logic [9:0] a, input logic [31:0] d);
    bus.daddr   = a;
    bus.ddata_w = d;
    bus.d_rw    = 1'b1;
    tick();
    bus.d_rw    = 1'b0;
  endtask

  task automatic chk_irq(input string tag, input logic e);
    chk(tag, {31'b0, timer_irq}, {31'b0, e});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    RESET       = 1'b1;
    gpio_in     = 8'h00;
    bus.daddr   = 10'h200;
    bus.ddata_w = 32'h0;
    bus.d_rw    = 1'b0;
    cyc         = 32'h0;
    #10;
    chk("rst_gpio_out", {24'b0, gpio_out}, 32'h0);
    chk_irq("rst_irq", 1'b0);
    rd(10'h200, 32'h0, "rst_cycle");
    rd(10'h204, 32'h0, "rst_tcmp");
    rd(10'h214, 32'h0, "rst_gpio_in");

    @(negedge CLK);
    RESET = 1'b0;
    cyc   = 32'h0;
    rd(10'h200, 32'd0, "cycle_0");
    tick();
    rd(10'h200, 32'd1, "cycle_1");
    repeat (3) tick();
    rd(10'h200, cyc, "cycle_4");

    // RAM, including same-cycle write/read returning the old word
    wr(10'h004, 32'h1111_1111);
    bus.daddr   = 10'h004;
    bus.ddata_w = 32'hDEAD_BEEF;
    bus.d_rw    = 1'b1;
    exp_q.push_back(32'h1111_1111);
    tag_q.push_back("ram_old_in_write_cycle");
    #1;
    chk(tag_q.pop_front(), bus.ddata_r, exp_q.pop_front());
    tick();
    bus.d_rw = 1'b0;
    rd(10'h004, 32'hDEAD_BEEF, "ram_new_next_cycle");
    wr(10'h1FC, 32'h1234_5678);
    rd(10'h1FC, 32'h1234_5678, "ram_top_word");
    rd(10'h004, 32'hDEAD_BEEF, "ram_word1_kept");
    rd(10'h200, cyc, "cycle_after_ram");

    // GPIO out and input synchroniser
    wr(10'h210, 32'h0000_00A5);
    chk("gpio_out_pin", {24'b0, gpio_out}, 32'hA5);
    rd(10'h210, 32'hA5, "gpio_out_rd");
    rd(10'h3F0, 32'hA5, "gpio_out_alias");
    gpio_in = 8'h3C;
    rd(10'h214, 32'h0, "gpio_in_edge0");
    tick();
    rd(10'h214, 32'h0, "gpio_in_edge1");
    tick();
    rd(10'h214, 32'h3C, "gpio_in_edge2");

    // Timer enabled: flag rises on the edge after CYCLE==TCMP
    t = cyc + 32'd5;
    wr(10'h204, t);
    wr(10'h208, 32'h1);
    rd(10'h208, 32'h1, "tctrl_en");
    rd(10'h204, t, "tcmp_rd");
    while (cyc != t) begin
      chk_irq("irq_before_match", 1'b0);
      tick();
    end
    chk_irq("irq_at_match", 1'b0);
    tick();
    chk_irq("irq_after_match", 1'b1);
    rd(10'h20C, 32'h1, "tstat_set");
    wr(10'h204, 32'h0000_0001);
    chk_irq("irq_tcmp_write_keeps", 1'b1);
    wr(10'h20C, 32'h0);
    chk_irq("irq_w0_keeps", 1'b1);
    wr(10'h20C, 32'h1);
    chk_irq("irq_w1c", 1'b0);

    // Clear on the match edge: set wins
    t = cyc + 32'd3;
    wr(10'h204, t);
    while (cyc != t) tick();
    wr(10'h20C, 32'h1);
    chk_irq("irq_set_wins", 1'b1);
    wr(10'h20C, 32'h1);
    chk_irq("irq_clear_after", 1'b0);

    // Timer disabled: CYCLE passes TCMP without setting the flag
    wr(10'h208, 32'h0);
    t = cyc + 32'd3;
    wr(10'h204, t);
    repeat (6) begin
      tick();
      chk_irq("irq_disabled", 1'b0);
    end
    rd(10'h20C, 32'h0, "tstat_disabled");

    // Read-only / reserved registers
    wr(10'h218, 32'hFFFF_FFFF);
    rd(10'h218, 32'h0, "reserved_6");
    rd(10'h21C, 32'h0, "reserved_7");
    wr(10'h208, 32'hFFFF_FFFE);
    rd(10'h208, 32'h0, "tctrl_upper_bits");
    wr(10'h200, 32'h0);
    rd(10'h200, cyc, "cycle_ro");
    wr(10'h214, 32'hFF);
    rd(10'h214, 32'h3C, "gpio_in_ro");

    // CYCLE wrap via backdoor
    force dut.cycle_q = 32'hFFFF_FFFE;
    #1;
    release dut.cycle_q;
    cyc = 32'hFFFF_FFFE;
    rd(10'h200, 32'hFFFF_FFFE, "cycle_preset");
    tick();
    rd(10'h200, 32'hFFFF_FFFF, "cycle_max");
    tick();
    rd(10'h200, 32'h0, "cycle_wrap");

    // Asynchronous reset between edges
    t = cyc + 32'd2;
    wr(10'h204, t);
    wr(10'h208, 32'h1);
    tick();
    chk_irq("irq_before_reset", 1'b1);
    #10;
    RESET = 1'b1;
    #1;
    chk("midrst_gpio_out", {24'b0, gpio_out}, 32'h0);
    chk_irq("midrst_irq", 1'b0);
    rd(10'h200, 32'h0, "midrst_cycle");
    rd(10'h3FC, 32'h0, "midrst_mmio_7");
    @(negedge CLK);
    RESET = 1'b0;
    cyc   = 32'h0;
    rd(10'h004, 32'hDEAD_BEEF, "ram_survives_reset_a");
    rd(10'h1FC, 32'h1234_5678, "ram_survives_reset_b");
    rd(10'h204, 32'h0, "tcmp_after_reset");
    tick();
    rd(10'h200, 32'd1, "cycle_after_reset");
    rd(10'h208, 32'h0, "tctrl_after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule
